// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: pointer sizing, wrapping increment, error-flag indices.
package fifo_pkg;

    // Minimum of one address bit so a degenerate depth still yields a legal vector.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit wrap at depth-1, so non-power-of-two depths never rely on natural overflow.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    typedef enum logic [0:0] {
        ERR_OVERFLOW  = 1'b0,
        ERR_UNDERFLOW = 1'b1
    } err_idx_e;

    localparam int unsigned ERR_NUM = 2;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read (required for fall-through head).
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with threshold flags, fill level and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned MEMORY_WIDTH  = 8,
    parameter int unsigned MEMORY_DEPTH  = 8,
    parameter int unsigned POINTER_WIDTH = ptr_width(MEMORY_DEPTH),
    parameter int unsigned AF_THRESH     = MEMORY_DEPTH - 1,
    parameter int unsigned AE_THRESH     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic                     rdEn,
    input  logic                     clrErr,
    input  logic [MEMORY_WIDTH-1:0]  inData,
    output logic [MEMORY_WIDTH-1:0]  outData,
    output logic                     rdValid,
    output logic                     full,
    output logic                     empty,
    output logic                     almostFull,
    output logic                     almostEmpty,
    output logic [POINTER_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned LW = POINTER_WIDTH + 1;

    logic [POINTER_WIDTH-1:0] wr_ptr;
    logic [POINTER_WIDTH-1:0] rd_ptr;
    logic [MEMORY_WIDTH-1:0]  head;
    logic                     rd_acc;
    logic                     wr_acc;
    logic [ERR_NUM-1:0]       err;

    // Flags decode straight from the registered level.
    assign empty       = (level == '0);
    assign full        = (level == LW'(MEMORY_DEPTH));
    assign almostFull  = (level >= LW'(AF_THRESH));
    assign almostEmpty = (level <= LW'(AE_THRESH));

    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign rd_acc = rdEn && !empty;
    assign wr_acc = wrEn && (!full || rd_acc);

    fifo_mem #(
        .WIDTH (MEMORY_WIDTH),
        .DEPTH (MEMORY_DEPTH),
        .AW    (POINTER_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (inData),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= POINTER_WIDTH'(ptr_next(32'(wr_ptr), MEMORY_DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= POINTER_WIDTH'(ptr_next(32'(rd_ptr), MEMORY_DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // Set has priority over clear.
            err[ERR_OVERFLOW]  <= (wrEn && !wr_acc) || (err[ERR_OVERFLOW]  && !clrErr);
            err[ERR_UNDERFLOW] <= (rdEn && !rd_acc) || (err[ERR_UNDERFLOW] && !clrErr);
        end
    end

    assign overflow  = err[ERR_OVERFLOW];
    assign underflow = err[ERR_UNDERFLOW];

`ifdef FIFO_FWFT_EN
    assign outData = head;
    assign rdValid = !empty;
`else
    // Registered read port: data holds between reads, valid pulses once per accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outData <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rd_acc;
            if (rd_acc) begin
                outData <= head;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (depth 6, thresholds 5/1); follows FIFO_FWFT_EN if defined.
module tb_fifo_sync_param;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 6;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned AF = 5;
    localparam int unsigned AE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrEn;
    logic          rdEn;
    logic          clrErr;
    logic [W-1:0]  inData;
    logic [W-1:0]  outData;
    logic          rdValid;
    logic          full;
    logic          empty;
    logic          almostFull;
    logic          almostEmpty;
    logic [PW:0]   level;
    logic          overflow;
    logic          underflow;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    int           m_level;
    bit           m_ovf;
    bit           m_udf;

    fifo_sync_param #(
        .MEMORY_WIDTH (W),
        .MEMORY_DEPTH (D),
        .AF_THRESH    (AF),
        .AE_THRESH    (AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .rdEn        (rdEn),
        .clrErr      (clrErr),
        .inData      (inData),
        .outData     (outData),
        .rdValid     (rdValid),
        .full        (full),
        .empty       (empty),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; queues the expected read word and checks occupancy/error state.
    task automatic cycle(input bit we, input bit re, input bit clr, input logic [W-1:0] d);
        bit ra;
        bit wa;
        wrEn   = we;
        rdEn   = re;
        clrErr = clr;
        inData = d;
        ra = re && (m_level > 0);
        wa = we && ((m_level < int'(D)) || ra);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        m_level += int'(wa) - int'(ra);
        m_ovf = (we && !wa) || (m_ovf && !clr);
        m_udf = (re && !ra) || (m_udf && !clr);
        @(posedge clk);
        #1;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        clrErr = 1'b0;
        check("level",       32'(level),       32'(m_level));
        check("empty",       32'(empty),       32'(m_level == 0));
        check("full",        32'(full),        32'(m_level == int'(D)));
        check("almostFull",  32'(almostFull),  32'(m_level >= int'(AF)));
        check("almostEmpty", 32'(almostEmpty), 32'(m_level <= int'(AE)));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("underflow",   32'(underflow),   32'(m_udf));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always @(negedge clk) begin
`ifdef FIFO_FWFT_EN
        if (rst && rdEn && rdValid) begin
`else
        if (rst && rdValid) begin
`endif
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got 0x%0h required no valid word", outData);
            end else begin
                check("rd_data", 32'(outData), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        wrEn    = 1'b0;
        rdEn    = 1'b0;
        clrErr  = 1'b0;
        inData  = '0;
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level",       32'(level),       32'd0);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_almostEmpty", 32'(almostEmpty), 32'd1);
        check("rst_full",        32'(full),        32'd0);
        check("rst_almostFull",  32'(almostFull),  32'd0);
        check("rst_rdValid",     32'(rdValid),     32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        check("rst_underflow",   32'(underflow),   32'd0);
`ifndef FIFO_FWFT_EN
        check("rst_outData",     32'(outData),     32'd0);
`endif
        rst = 1'b1;

        // Fill 0x11..0x16, then drain.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
            check("fill_almostFull", 32'(almostFull), 32'(i + 1 >= 5));
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_level", 32'(level), 32'd6);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
        check("drain_last", 32'(outData), 32'h16);
`endif
        check("drain_empty", 32'(empty), 32'd1);

        // 12 words through with overlapping reads: both pointers wrap twice.
        for (int i = 0; i < 4; i++)  cycle(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
        for (int i = 4; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 8'h20 + 8'(i));
        check("wrap_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        check("fullrw_level",    32'(level),    32'd6);
        check("fullrw_overflow", 32'(overflow), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'hBB);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'd6);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow, set-beats-clear, then clear.
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("udf_set",     32'(underflow), 32'd1);
        check("udf_rdValid", 32'(rdValid),   32'd0);
        check("udf_level",   32'(level),     32'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        check("udf_setwins", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("udf_clr", 32'(underflow), 32'd0);
        check("ovf_clr", 32'(overflow),  32'd0);

        // Asynchronous reset mid-stream at level 4.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("pre_rst_level", 32'(level), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_level",   32'(level),   32'd0);
        check("arst_empty",   32'(empty),   32'd1);
        check("arst_rdValid", 32'(rdValid), 32'd0);
`ifndef FIFO_FWFT_EN
        check("arst_outData", 32'(outData), 32'd0);
`endif
        model_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word after reset; valid must drop once reads stop.
        cycle(1'b1, 1'b0, 1'b0, 8'h77);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("rdValid_drop", 32'(rdValid), 32'd0);

`ifdef FIFO_FWFT_EN
        cycle(1'b1, 1'b0, 1'b0, 8'h5A);
        check("fwft_outData", 32'(outData), 32'h5A);
        check("fwft_rdValid", 32'(rdValid), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("fwft_empty", 32'(empty), 32'd1);
`endif

        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, the successor to the fixed 8×8 FIFO. Adds arbitrary (non-power-of-two) depth, simultaneous read/write in the same cycle, programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. Optional first-word fall-through read mode. Sits between a producer and a consumer inside one clock domain; any input conditioning (debouncing, edge detection) is done upstream.

## Interface
- `MEMORY_WIDTH`, 8: data word width in bits, ≥1.
- `MEMORY_DEPTH`, 8: number of entries, ≥2; need not be a power of two.
- `POINTER_WIDTH`, `$clog2(MEMORY_DEPTH)`: read/write pointer width (derived).
- `AF_THRESH`, `MEMORY_DEPTH-1`: `almostFull` asserts when level ≥ this value; range 1..`MEMORY_DEPTH`.
- `AE_THRESH`, 1: `almostEmpty` asserts when level ≤ this value; range 0..`MEMORY_DEPTH-1`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wrEn` in 1: write request; single-cycle qualifier, sampled every clock.
- `rdEn` in 1: read request (standard mode) or head acknowledge (FWFT mode).
- `clrErr` in 1: synchronous clear of `overflow` and `underflow`.
- `inData` in `MEMORY_WIDTH`: write data.
- `outData` out `MEMORY_WIDTH`: read data.
- `rdValid` out 1: `outData` holds a valid word.
- `full`, `empty` out 1: occupancy flags.
- `almostFull`, `almostEmpty` out 1: threshold flags.
- `level` out `POINTER_WIDTH+1`: current entry count, 0..`MEMORY_DEPTH`.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- State: write pointer `wrPtr`, read pointer `rdPtr`, occupancy counter `level`, storage array.
- Both pointers wrap explicitly from `MEMORY_DEPTH-1` to 0; pointer arithmetic never relies on natural overflow.
- Read accept `rdAcc = rdEn && !empty`.
- Write accept `wrAcc = wrEn && (!full || rdAcc)`.
  - A write to a full FIFO succeeds if a read is accepted in the same cycle.
  - A read on an empty FIFO never succeeds, even with a concurrent write.
- Level update: write only → +1; read only → −1; both or neither → unchanged.
- Flag definitions:
  - `full = (level == MEMORY_DEPTH)`
  - `empty = (level == 0)`
  - `almostFull = (level >= AF_THRESH)`
  - `almostEmpty = (level <= AE_THRESH)`
- Error flags:
  - `overflow` sets on `wrEn && !wrAcc`.
  - `underflow` sets on `rdEn && !rdAcc`.
  - Both hold until `clrErr` or reset. If a set condition and `clrErr` occur in the same cycle, set wins.
  - A rejected operation never changes pointers, level or storage.
- Reset values:
  - `wrPtr`, `rdPtr`, `level` = 0.
  - `outData` = 0, `rdValid` = 0.
  - `overflow`, `underflow` = 0.
  - `empty` = 1, `almostEmpty` = 1, `full` = 0, `almostFull` = 0 (when `AF_THRESH` ≥ 1).
  - Storage is not reset.
- Reset asserted mid-operation discards all contents immediately, with no clock required.

## Timing
- All flags and `level` are decoded from registered state; they reflect an accepted operation in the cycle after the clock edge that accepted it.
- Standard mode read latency is 1 cycle: the word appears on `outData` after the accepting edge, and `rdValid` pulses high for exactly that one cycle.
- `outData` holds its last value when no read is accepted.
- Write-to-read turnaround on an empty FIFO is 1 cycle: the write edge clears `empty`, and the earliest accepted read is at the following edge.

## Configuration
- `FIFO_FWFT_EN` defined: first-word fall-through mode.
  - `outData` continuously shows the head entry, `mem[rdPtr]`.
  - `rdValid = !empty`.
  - `rdEn` pops the head; the next entry is visible the cycle after the pop.
  - A word written to an empty FIFO is visible on `outData` one cycle after the write edge.
  - The `outData` reset value is not guaranteed; `rdValid` = 0 in reset.
- `FIFO_FWFT_EN` undefined: standard registered read, as described in Timing.

## Structure
- Package `fifo_pkg`:
  - Localparam helper for pointer width.
  - Pointer-increment-with-wrap function, shared by both pointers.
  - Error-flag enum/encoding, reused by future FIFO variants.
- Sub-module `fifo_mem`:
  - Dual-port register array.
  - Synchronous write port; asynchronous read port (needed for FWFT).
  - Standard-mode registering of the read data lives in the top level.

## Test plan
Unless noted, the bench uses `MEMORY_WIDTH` = 8, `MEMORY_DEPTH` = 6, `AF_THRESH` = 5, `AE_THRESH` = 1.
- Write 0x11..0x16 → `full` = 1 and `level` = 6 after the 6th edge, `almostFull` = 1 from `level` 5. Read six times → `outData` sequence 0x11..0x16, `empty` = 1.
- Write 0x20..0x2B with interleaved reads, so pointers wrap twice → data order preserved across wrap at index 5→0; `level` is never >6 or <0.
- Full FIFO, `wrEn` = `rdEn` = 1 with 0xAA → head word read, 0xAA accepted, `level` stays 6, `overflow` stays 0.
- Empty FIFO, `rdEn` = 1 → `underflow` = 1, `rdValid` = 0, `level` = 0. Assert `clrErr` → `underflow` = 0 next cycle. Write to full with no read → `overflow` = 1, contents unchanged.
- Assert `rst` low asynchronously mid-stream at `level` = 4 → `level` = 0, `empty` = 1, `outData` = 0 before the next clock edge.
- With `FIFO_FWFT_EN`: write 0x5A into an empty FIFO → `outData` = 0x5A and `rdValid` = 1 one cycle later, with no `rdEn`. Pulse `rdEn` → `empty` = 1 next cycle.
